// File: rtl/script_stack_engine.sv
// Bitcoin-script execution core: fetches script bytes, runs push and stack opcodes
// locally and hands arithmetic/hash opcodes to an external ALU over req/ack.
module script_stack_engine #(
    parameter int STACK_DEPTH = 20,
    parameter int ELEM_WIDTH  = 512,
    parameter int MEM_DEPTH   = 512
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(MEM_DEPTH+1)-1:0]   script_len,
    output logic                             mem_rd_en,
    output logic [$clog2(MEM_DEPTH)-1:0]     mem_addr,
    input  logic [7:0]                       mem_rdata,
    output logic                             alu_req,
    output logic [7:0]                       alu_opcode,
    output logic [ELEM_WIDTH-1:0]            alu_a,
    output logic [ELEM_WIDTH-1:0]            alu_b,
    input  logic                             alu_ack,
    input  logic [ELEM_WIDTH-1:0]            alu_result,
    input  logic                             alu_fail,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [2:0]                       err_code,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic [ELEM_WIDTH-1:0]            top
);
    localparam int LW = $clog2(MEM_DEPTH+1);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int DW = $clog2(STACK_DEPTH+1);
    localparam logic [8:0]    MAX_BYTES = 9'(ELEM_WIDTH/8);
    localparam logic [DW-1:0] FULL      = DW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_LEN, S_PUSH, S_ALU_WAIT, S_FINISH
    } state_t;

    state_t                state_reg;
    state_t                ret_reg;
    logic [LW-1:0]         pc_reg;
    logic [LW-1:0]         len_reg;
    logic [DW-1:0]         depth_reg;
    logic [7:0]            cnt_reg;
    logic [ELEM_WIDTH-1:0] acc_reg;
    logic                  error_reg;
    logic [2:0]            err_code_reg;
    logic [7:0]            alu_opcode_reg;
    logic [ELEM_WIDTH-1:0] alu_a_reg;
    logic [ELEM_WIDTH-1:0] alu_b_reg;
    logic                  alu_unary_reg;
    logic [ELEM_WIDTH-1:0] stack_reg [STACK_DEPTH];

    logic [DW-1:0]         dm1;
    logic [DW-1:0]         dm2;
    logic [ELEM_WIDTH-1:0] top_val;
    logic [ELEM_WIDTH-1:0] sec_val;
    logic [ELEM_WIDTH-1:0] push_word;
    logic [ELEM_WIDTH-1:0] small_val;
    logic                  is_small;
    logic                  is_direct;
    logic                  is_binary;
    logic                  is_unary;
    logic                  full;
    logic                  len_big;
    logic [2:0]            dec_err;

    assign dm1       = depth_reg - DW'(1);
    assign dm2       = depth_reg - DW'(2);
    assign full      = (depth_reg == FULL);
    assign top_val   = (depth_reg == '0) ? '0 : stack_reg[dm1];
    assign sec_val   = (depth_reg < DW'(2)) ? '0 : stack_reg[dm2];
    assign push_word = (acc_reg << 8) | ELEM_WIDTH'(mem_rdata);
    assign small_val = (mem_rdata == 8'h00) ? '0 : ELEM_WIDTH'(mem_rdata - 8'h50);
    assign is_small  = (mem_rdata == 8'h00) || (mem_rdata >= 8'h51 && mem_rdata <= 8'h60);
    assign is_direct = (mem_rdata >= 8'h01) && (mem_rdata <= 8'h4B);
    assign is_binary = (mem_rdata >= 8'h93) && (mem_rdata <= 8'hA5);
    assign is_unary  = (mem_rdata >= 8'hA6) && (mem_rdata <= 8'hAA);
    assign len_big   = {1'b0, mem_rdata} > MAX_BYTES;

    // Every DECODE-time error is resolved here so the stack is never touched on failure.
    always_comb begin
        dec_err = 3'd0;
        if (is_small) begin
            if (full) dec_err = 3'd1;
        end else if (is_direct) begin
            if (len_big) dec_err = 3'd4;
        end else if (is_binary) begin
            if (depth_reg < DW'(2)) dec_err = 3'd2;
        end else if (is_unary) begin
            if (depth_reg == '0) dec_err = 3'd2;
        end else begin
            case (mem_rdata)
                8'h4C: dec_err = 3'd0;
                8'h69: if (depth_reg == '0) dec_err = 3'd2;
                       else if (top_val == '0) dec_err = 3'd5;
                8'h75: if (depth_reg == '0) dec_err = 3'd2;
                8'h76: if (depth_reg == '0) dec_err = 3'd2;
                       else if (full) dec_err = 3'd1;
                8'h7C, 8'h87: if (depth_reg < DW'(2)) dec_err = 3'd2;
                8'h88: if (depth_reg < DW'(2)) dec_err = 3'd2;
                       else if (top_val != sec_val) dec_err = 3'd5;
                default: dec_err = 3'd3;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            ret_reg        <= S_DECODE;
            pc_reg         <= '0;
            len_reg        <= '0;
            depth_reg      <= '0;
            cnt_reg        <= '0;
            acc_reg        <= '0;
            error_reg      <= 1'b0;
            err_code_reg   <= 3'd0;
            alu_opcode_reg <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_unary_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_FINISH: if (start) begin
                    pc_reg       <= '0;
                    depth_reg    <= '0;
                    error_reg    <= 1'b0;
                    err_code_reg <= 3'd0;
                    len_reg      <= script_len;
                    ret_reg      <= S_DECODE;
                    state_reg    <= S_FETCH;
                end
                S_FETCH: begin
                    if (pc_reg == len_reg) begin
                        state_reg <= S_FINISH;
                        // Running out of bytes mid-push is truncation; otherwise judge the result.
                        if (ret_reg != S_DECODE) begin
                            error_reg <= 1'b1; err_code_reg <= 3'd4;
                        end else if (top_val == '0) begin
                            error_reg <= 1'b1; err_code_reg <= 3'd6;
                        end
                    end else begin
                        pc_reg    <= pc_reg + LW'(1);
                        state_reg <= ret_reg;
                    end
                end
                S_DECODE: begin
                    state_reg <= S_FETCH;
                    ret_reg   <= S_DECODE;
                    if (dec_err != 3'd0) begin
                        error_reg <= 1'b1; err_code_reg <= dec_err; state_reg <= S_FINISH;
                    end else if (is_small) begin
                        stack_reg[depth_reg] <= small_val;
                        depth_reg            <= depth_reg + DW'(1);
                    end else if (is_direct) begin
                        cnt_reg <= mem_rdata;
                        acc_reg <= '0;
                        ret_reg <= S_PUSH;
                    end else if (is_binary || is_unary) begin
                        alu_opcode_reg <= mem_rdata;
                        alu_a_reg      <= top_val;
                        alu_b_reg      <= is_binary ? sec_val : '0;
                        alu_unary_reg  <= is_unary;
                        state_reg      <= S_ALU_WAIT;
                    end else begin
                        case (mem_rdata)
                            8'h4C: ret_reg <= S_LEN;
                            8'h69, 8'h75: depth_reg <= dm1;
                            8'h76: begin
                                stack_reg[depth_reg] <= top_val;
                                depth_reg            <= depth_reg + DW'(1);
                            end
                            8'h7C: begin
                                stack_reg[dm1] <= sec_val;
                                stack_reg[dm2] <= top_val;
                            end
                            8'h87: begin
                                stack_reg[dm2] <= ELEM_WIDTH'(top_val == sec_val);
                                depth_reg      <= dm1;
                            end
                            8'h88: depth_reg <= dm2;
                            default: depth_reg <= depth_reg;
                        endcase
                    end
                end
                S_LEN: begin
                    state_reg <= S_FETCH;
                    if (len_big) begin
                        error_reg <= 1'b1; err_code_reg <= 3'd4; state_reg <= S_FINISH;
                    end else if (mem_rdata == 8'h00) begin
                        ret_reg <= S_DECODE;
                        if (full) begin
                            error_reg <= 1'b1; err_code_reg <= 3'd1; state_reg <= S_FINISH;
                        end else begin
                            stack_reg[depth_reg] <= '0;
                            depth_reg            <= depth_reg + DW'(1);
                        end
                    end else begin
                        cnt_reg <= mem_rdata;
                        acc_reg <= '0;
                        ret_reg <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    state_reg <= S_FETCH;
                    acc_reg   <= push_word;
                    cnt_reg   <= cnt_reg - 8'd1;
                    if (cnt_reg == 8'd1) begin
                        ret_reg <= S_DECODE;
                        if (full) begin
                            error_reg <= 1'b1; err_code_reg <= 3'd1; state_reg <= S_FINISH;
                        end else begin
                            stack_reg[depth_reg] <= push_word;
                            depth_reg            <= depth_reg + DW'(1);
                        end
                    end
                end
                S_ALU_WAIT: if (alu_ack) begin
                    if (alu_fail) begin
                        error_reg <= 1'b1; err_code_reg <= 3'd7; state_reg <= S_FINISH;
                    end else begin
                        state_reg <= S_FETCH;
                        if (alu_unary_reg) begin
                            stack_reg[dm1] <= alu_result;
                        end else begin
                            stack_reg[dm2] <= alu_result;
                            depth_reg      <= dm1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign mem_rd_en  = (state_reg == S_FETCH) && (pc_reg != len_reg);
    assign mem_addr   = pc_reg[AW-1:0];
    assign alu_req    = (state_reg == S_ALU_WAIT);
    assign alu_opcode = alu_opcode_reg;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_FINISH);
    assign done       = (state_reg == S_FINISH);
    assign error      = error_reg;
    assign err_code   = err_code_reg;
    assign depth      = depth_reg;
    assign top        = top_val;
endmodule

// File: tb/tb_script_stack_engine.sv
// Bench for script_stack_engine: directed scripts plus random scripts compared
// against a queue-based interpreter of the script rules.
`timescale 1ns/1ps
module tb_script_stack_engine;
    localparam int SD = 20;
    localparam int EW = 512;
    localparam int MD = 512;
    typedef logic [7:0]    u8;
    typedef logic [EW-1:0] w_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    script_len;
    logic          mem_rd_en;
    logic [8:0]    mem_addr;
    logic [7:0]    mem_rdata;
    logic          alu_req;
    logic [7:0]    alu_opcode;
    logic [EW-1:0] alu_a;
    logic [EW-1:0] alu_b;
    logic          alu_ack;
    logic [EW-1:0] alu_result;
    logic          alu_fail;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    err_code;
    logic [4:0]    depth;
    logic [EW-1:0] top;

    int checks = 0;
    int errors = 0;
    int last_cyc = 0;
    int alu_lat = 2;
    bit alu_fail_mode = 0;
    bit alu_unstable = 0;
    bit alu_stuck = 0;
    u8  cap_op;
    w_t cap_a;
    w_t cap_b;
    u8  mem [MD];

    script_stack_engine dut (
        .clk(clk), .rst(rst), .start(start), .script_len(script_len),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .alu_req(alu_req), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ack(alu_ack), .alu_result(alu_result), .alu_fail(alu_fail),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .depth(depth), .top(top)
    );

    always #5 clk = ~clk;

    // Script memory: a read requested in FETCH presents data before the consume edge.
    initial begin
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_rd_en) mem_rdata = mem[mem_addr];
        end
    end

    // ALU model: binary ops add, unary ops increment; acks after alu_lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        alu_ack = 1'b0; alu_fail = 1'b0; alu_result = '0;
        forever begin
            @(negedge clk);
            if (alu_ack) begin
                if (alu_req) alu_stuck = 1;
                alu_ack = 1'b0; alu_fail = 1'b0; cnt = 0;
            end else if (alu_req) begin
                if (cnt == 0) begin
                    cap_op = alu_opcode; cap_a = alu_a; cap_b = alu_b;
                end else if (alu_opcode !== cap_op || alu_a !== cap_a || alu_b !== cap_b) begin
                    alu_unstable = 1;
                end
                cnt++;
                if (cnt >= alu_lat) begin
                    alu_ack    = 1'b1;
                    alu_fail   = alu_fail_mode;
                    alu_result = (alu_opcode >= 8'hA6) ? alu_a + w_t'(1) : alu_a + alu_b;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference interpreter working directly on a queue of stack values.
    function automatic void ref_run(input u8 s[$], input bit afail, output int code,
                                    output int dep, output w_t tp, output bit offl);
        w_t st[$];
        w_t a, b, v;
        int pc, n;
        u8 op;
        pc = 0; code = 0; offl = 0;
        while (code == 0) begin
            if (pc == s.size()) begin
                if (st.size() == 0 || st[st.size()-1] == '0) code = 6;
                break;
            end
            op = s[pc]; pc++;
            if (op == 8'h00 || (op >= 8'h51 && op <= 8'h60)) begin
                if (st.size() == SD) code = 1;
                else st.push_back(op == 8'h00 ? w_t'(0) : w_t'(op - 8'h50));
            end else if (op >= 8'h01 && op <= 8'h4C) begin
                if (op == 8'h4C) begin
                    if (pc == s.size()) begin code = 4; break; end
                    n = int'(s[pc]); pc++;
                end else n = int'(op);
                if (n > EW/8 || pc + n > s.size()) code = 4;
                else begin
                    v = '0;
                    for (int j = 0; j < n; j++) v = (v << 8) | w_t'(s[pc+j]);
                    pc += n;
                    if (st.size() == SD) code = 1; else st.push_back(v);
                end
            end else if (op >= 8'h93 && op <= 8'hAA) begin
                offl = 1;
                if (st.size() < ((op <= 8'hA5) ? 2 : 1)) code = 2;
                else if (afail) code = 7;
                else begin
                    a = st.pop_back();
                    if (op <= 8'hA5) begin b = st.pop_back(); st.push_back(a + b); end
                    else st.push_back(a + w_t'(1));
                end
            end else begin
                case (op)
                    8'h69: if (st.size() < 1) code = 2;
                           else if (st[st.size()-1] == '0) code = 5;
                           else a = st.pop_back();
                    8'h75: if (st.size() < 1) code = 2; else a = st.pop_back();
                    8'h76: if (st.size() < 1) code = 2;
                           else if (st.size() == SD) code = 1;
                           else st.push_back(st[st.size()-1]);
                    8'h7C: if (st.size() < 2) code = 2;
                           else begin a = st.pop_back(); b = st.pop_back(); st.push_back(a); st.push_back(b); end
                    8'h87: if (st.size() < 2) code = 2;
                           else begin a = st.pop_back(); b = st.pop_back(); st.push_back(w_t'(a == b)); end
                    8'h88: if (st.size() < 2) code = 2;
                           else if (st[st.size()-1] != st[st.size()-2]) code = 5;
                           else begin a = st.pop_back(); b = st.pop_back(); end
                    default: code = 3;
                endcase
            end
        end
        dep = st.size();
        tp  = (st.size() == 0) ? w_t'(0) : st[st.size()-1];
    endfunction

    task automatic gen_script(output u8 s[$]);
        int nops, k, m;
        s = {};
        nops = $urandom_range(1, 8);
        for (int i = 0; i < nops; i++) begin
            k = $urandom_range(0, 15);
            case (k)
                0, 1, 2: s.push_back(8'($urandom_range(8'h51, 8'h60)));
                3: s.push_back(8'h00);
                4: begin
                    m = $urandom_range(1, 4);
                    s.push_back(8'(m));
                    for (int j = 0; j < m; j++) s.push_back(8'($urandom));
                end
                5: begin
                    m = $urandom_range(0, 3);
                    s.push_back(8'h4C); s.push_back(8'(m));
                    for (int j = 0; j < m; j++) s.push_back(8'($urandom));
                end
                6: s.push_back(8'h69);
                7: s.push_back(8'h75);
                8, 9: s.push_back(8'h76);
                10: s.push_back(8'h7C);
                11: s.push_back(8'h87);
                12: s.push_back(8'h88);
                13: s.push_back(8'h93);
                14: s.push_back(8'hA6);
                default: s.push_back(8'hBA);
            endcase
        end
        if (s.size() > 1 && $urandom_range(0, 9) == 0) s.pop_back();
    endtask

    task automatic load_start(input u8 s[$]);
        for (int i = 0; i < MD; i++) mem[i] = (i < s.size()) ? s[i] : 8'($urandom);
        alu_unstable = 0; alu_stuck = 0; cap_op = '0; cap_a = '0; cap_b = '0;
        @(posedge clk); #1;
        start = 1'b1; script_len = 10'(s.size());
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 0;
        while (!done && cyc < 5000) begin @(posedge clk); #1; cyc++; end
        last_cyc = cyc + 1;
        chk({tag, " done"}, w_t'(done), 1);
    endtask

    task automatic run_check(input string tag, input u8 s[$], input bit afail, input int lat);
        int code, dep;
        w_t tp;
        bit offl;
        ref_run(s, afail, code, dep, tp, offl);
        alu_fail_mode = afail; alu_lat = lat;
        load_start(s);
        wait_done(tag);
        $display("%s len=%0d err_code=%0d depth=%0d cycles=%0d", tag, s.size(), err_code, depth, last_cyc);
        chk({tag, " error"}, w_t'(error), w_t'(code != 0));
        chk({tag, " err_code"}, w_t'(err_code), w_t'(code));
        chk({tag, " depth"}, w_t'(depth), w_t'(dep));
        chk({tag, " top"}, top, tp);
        if (!offl && (code == 0 || code == 6))
            chk({tag, " latency"}, w_t'(last_cyc), w_t'(2 + 2 * s.size()));
    endtask

    initial begin
        u8 s[$];
        int cyc;
        rst = 1'b1; start = 1'b0; script_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst done", w_t'(done), 0);
        chk("rst error", w_t'(error), 0);
        chk("rst err_code", w_t'(err_code), 0);
        chk("rst busy", w_t'(busy), 0);
        chk("rst alu_req", w_t'(alu_req), 0);
        chk("rst alu_opcode", w_t'(alu_opcode), 0);
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst mem_rd_en", w_t'(mem_rd_en), 0);
        chk("rst mem_addr", w_t'(mem_addr), 0);
        chk("rst depth", w_t'(depth), 0);
        chk("rst top", top, 0);

        s = '{8'h02, 8'hAB, 8'hCD, 8'h51};
        run_check("push2", s, 0, 2);
        chk("push2 done cycle", w_t'(last_cyc), 10);
        chk("push2 depth2", w_t'(depth), 2);
        chk("push2 top1", top, 1);
        s = '{8'h02, 8'hAB, 8'hCD, 8'h51, 8'h75};
        run_check("push2 drop", s, 0, 2);
        chk("stack0 value", top, 16'hABCD);

        s = '{8'h52, 8'h52, 8'h88, 8'h51};
        run_check("eqverify ok", s, 0, 2);
        chk("eqverify ok top", top, 1);
        s = '{8'h51, 8'h52, 8'h88};
        run_check("eqverify bad", s, 0, 2);
        chk("eqverify bad code", w_t'(err_code), 5);
        chk("eqverify bad depth", w_t'(depth), 2);
        s = '{8'h75};
        run_check("underflow", s, 0, 2);
        chk("underflow code", w_t'(err_code), 2);
        s = {};
        repeat (21) s.push_back(8'h51);
        run_check("overflow", s, 0, 2);
        chk("overflow code", w_t'(err_code), 1);
        chk("overflow depth", w_t'(depth), 20);
        s = '{8'hBA};
        run_check("bad opcode", s, 0, 2);
        chk("bad opcode code", w_t'(err_code), 3);

        s = '{8'h53, 8'h54, 8'h93};
        run_check("alu add", s, 0, 3);
        chk("alu add a", cap_a, 4);
        chk("alu add b", cap_b, 3);
        chk("alu add op", w_t'(cap_op), 8'h93);
        chk("alu add stable", w_t'(alu_unstable), 0);
        chk("alu req drop", w_t'(alu_stuck), 0);
        chk("alu add top", top, 7);
        run_check("alu fail", s, 1, 3);
        chk("alu fail code", w_t'(err_code), 7);
        chk("alu fail depth", w_t'(depth), 2);

        s = '{8'h03, 8'h01};
        run_check("truncated", s, 0, 2);
        chk("truncated code", w_t'(err_code), 4);
        s = '{8'h4C, 8'h41};
        run_check("pd1 too big", s, 0, 2);
        chk("pd1 too big code", w_t'(err_code), 4);
        s = '{8'h4C, 8'h00};
        run_check("pd1 zero", s, 0, 2);
        chk("pd1 zero code", w_t'(err_code), 6);
        chk("pd1 zero depth", w_t'(depth), 1);

        s = '{8'h51, 8'h51, 8'h93};
        alu_lat = 100000;
        load_start(s);
        cyc = 0;
        while (!alu_req && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("reach alu_wait", w_t'(alu_req), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst alu_req", w_t'(alu_req), 0);
        chk("midrst depth", w_t'(depth), 0);
        chk("midrst done", w_t'(done), 0);
        chk("midrst busy", w_t'(busy), 0);
        chk("midrst alu_opcode", w_t'(alu_opcode), 0);
        s = '{8'h51};
        run_check("after rst", s, 0, 2);
        chk("after rst code", w_t'(err_code), 0);

        for (int t = 0; t < 40; t++) begin
            gen_script(s);
            run_check($sformatf("rand%0d", t), s, ($urandom_range(0, 4) == 0), $urandom_range(1, 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/script_stack_engine.md
# script_stack_engine

Parametrised Bitcoin-script execution core: fetches script bytes from a synchronous-read byte memory, executes push and stack-manipulation opcodes internally on a STACK_DEPTH × ELEM_WIDTH stack, and offloads arithmetic/hash opcodes to an external ALU over a req/ack handshake. It reports completion, a pass/fail verdict and an error code. It is the next-generation replacement for the script top level: generalised widths, explicit memory port, PUSHDATA1, small-integer pushes, overflow/underflow detection and a real ALU handshake.

## Interface
- STACK_DEPTH, 20, number of stack elements
- ELEM_WIDTH, 512, bits per stack element; a multiple of 8; max push = ELEM_WIDTH/8 bytes
- MEM_DEPTH, 512, script memory bytes
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution at address 0; honoured only in IDLE or FINISH
- script_len  in  clog2(MEM_DEPTH+1)  valid script bytes; sampled with start
- mem_rd_en / mem_addr  out  1 / clog2(MEM_DEPTH)  read request; data valid the following cycle
- mem_rdata  in  8  read data
- alu_req  out  1  offload request; held until alu_ack
- alu_opcode  out  8  opcode being offloaded
- alu_a, alu_b  out  ELEM_WIDTH  top and second element (alu_b = 0 for unary)
- alu_ack  in  1  result valid this cycle
- alu_result  in  ELEM_WIDTH  result
- alu_fail  in  1  qualified by alu_ack; ALU rejected the operation
- busy  out  1  high in any state other than IDLE/FINISH
- done  out  1  level; high in FINISH
- error  out  1  level; valid when done
- err_code  out  3  0 none, 1 overflow, 2 underflow, 3 bad opcode, 4 push too big / truncated, 5 verify fail, 6 eval false, 7 ALU fail
- depth  out  clog2(STACK_DEPTH+1)  current element count
- top  out  ELEM_WIDTH  stack[depth-1], 0 when empty

## Operation
- States: IDLE, FETCH, DECODE, LEN, PUSH, ALU_WAIT, FINISH.
- start in IDLE/FINISH: PC←0, depth←0, error/err_code←0, latch script_len, go to FETCH.
- FETCH: if PC == script_len, go to FINISH (end-of-script in DECODE state context) or error 4 (in LEN/PUSH context). Otherwise assert mem_rd_en with mem_addr = PC, PC←PC+1, and go to the consuming state.
- DECODE opcodes:
  - 0x00: push 0.
  - 0x01–0x4B: N = opcode. If N > ELEM_WIDTH/8, error 4. Otherwise go to PUSH with count N, accumulator cleared.
  - 0x4C PUSHDATA1: fetch the length byte in LEN, apply the same N check, then go to PUSH. N = 0 pushes 0.
  - 0x51–0x60: push opcode−0x50.
  - 0x69 VERIFY: pop; if the value is zero, error 5.
  - 0x75 DROP: pop.
  - 0x76 DUP: push a copy of top.
  - 0x7C SWAP: exchange the top two elements.
  - 0x87 EQUAL: pop 2, push 1/0.
  - 0x88 EQUALVERIFY: pop 2; if the values are unequal, error 5.
  - 0x93–0xA5: binary offload (pop 2, push 1).
  - 0xA6–0xAA: unary offload (pop 1, push 1).
  - Any other opcode: error 3.
- PUSH: each byte is consumed as acc ← (acc<<8) | mem_rdata, so the first byte ends up most significant. The element is written on the consume cycle of the last byte.
- Underflow check (error 2): the operation needs more elements than depth.
- Overflow check (error 1): a push, including DUP, is attempted with depth == STACK_DEPTH.
- On any error the stack is left unmodified and the block goes to FINISH.
- Offload: enter ALU_WAIT.
  - alu_req = 1; alu_opcode, alu_a and alu_b are held stable.
  - Operands are popped and the result is pushed on the alu_ack cycle.
  - alu_fail=1 with alu_ack gives error 7.
  - alu_ack outside ALU_WAIT is ignored.
- End of script without error: if depth == 0 or top == 0, error 6; otherwise error = 0.

## Timing
- Reset values:
  - State IDLE; PC, depth and the accumulator are 0.
  - All outputs are 0: done, error, err_code, busy, alu_req, alu_opcode, alu_a, alu_b, mem_rd_en, mem_addr, depth, top.
- start sampled at cycle k puts the block in FETCH at cycle k+1.
- Every byte read costs 2 cycles: FETCH, then consume (DECODE/LEN/PUSH).
- Internal opcodes take 2 cycles. A push of N bytes takes 2+2N cycles; PUSHDATA1 adds 2.
- Offload opcodes take 2 cycles plus the ALU latency; alu_req deasserts the cycle after alu_ack.
- For an error-free script with no offloads, the end-check FETCH falls in cycle k+1+2·len and done rises at cycle k+2+2·len.
- Errors reach FINISH the cycle after detection.
- Stack writes, depth and top update at the end of the consume/ack cycle and are visible in the next cycle.
- rst takes priority over everything, including mid-push or mid-ALU_WAIT: all outputs return to reset values the next cycle, and no stack write occurs.
- A start that coincides with busy=1 is ignored.

## Test plan
- Script 02 AB CD 51, len 4, started at cycle 0 → done at cycle 10, error 0, depth 2, stack[0] = 0xABCD, top 1.
- Script 52 52 88 51 → done, error 0, depth 1, top 1. Script 51 52 88 → error 1 high, err_code 5, depth 2 unchanged.
- Script 75 → err_code 2, depth 0. Script of 21×51 with STACK_DEPTH=20 → err_code 1, depth 20. Script BA → err_code 3.
- Script 53 54 93, with the ALU model acking after 3 cycles → alu_a=4, alu_b=3, alu_opcode=0x93 held stable until ack; result 7 gives top 7, depth 1, error 0. Repeat with alu_fail → err_code 7, depth 2.
- Script 03 01 (len 2) → err_code 4. Script 4C 41 (ELEM_WIDTH=512) → err_code 4. Script 4C 00 → push 0, then err_code 6.
- Assert rst during ALU_WAIT → next cycle alu_req 0, depth 0, done 0. A fresh start then runs 51 to success.
